board_state_register: RTL

Parametrised successor of the Game of Life board register. Holds the current board, selects between host setup loads and algorithm next-generation results, and paces generations with a tick divider. Adds run/pause/single-step control, a valid/ready handshake toward the algorithm, a generation counter, and stable/extinct status. Sits between the setup loader, the next-state algorithm core and the display driver.

---
 rtl/board_pkg.sv | 32 +++
 rtl/board_state_register_tick.sv | 29 ++
 rtl/board_state_register.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// board_pkg: shared board geometry defaults, control-state and command encodings.
// Also provides cell_idx(r, c, cols) = r*cols + c for flattened board vectors.
package board_pkg;

  localparam int DEF_ROWS  = 16;
  localparam int DEF_COLS  = 16;
  localparam int DEF_CELLS = DEF_ROWS * DEF_COLS;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STEP  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RUN,
    CMD_STEP,
    CMD_PAUSE,
    CMD_EDIT
  } cmd_t;

  function automatic int cell_idx(
    input int r,
    input int c,
    input int cols
  );
    return r * cols + c;
  endfunction

endpackage

// File: rtl/board_state_register_tick.sv
// gen_tick_divider: counts 0..TICK_DIV-1 while enable, one-cycle tick on wrap.
// Ports: clk, reset (async, high), enable (low clears count), tick.
module gen_tick_divider #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] WRAP = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == WRAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || cnt == WRAP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/board_state_register.sv
// board_state_register: current board, setup/algorithm select, run/pause/step pacing.
// Ports: clk, reset, load_*, cmd_*, next_* handshake, board_out, generation,
// stable, extinct, state_out; period2 only when OSCILLATOR_DETECT_EN is defined.
module board_state_register
  import board_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int GEN_W    = 16,
  parameter int TICK_DIV = 1_000_000,
  localparam int CELLS   = ROWS * COLS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [CELLS-1:0] load_board,
  input  logic             cmd_run,
  input  logic             cmd_pause,
  input  logic             cmd_step,
  input  logic             cmd_edit,
  input  logic             next_valid,
  input  logic [CELLS-1:0] next_board,
  output logic             next_ready,
  output logic [CELLS-1:0] board_out,
  output logic [GEN_W-1:0] generation,
  output logic             stable,
  output logic             extinct,
`ifdef OSCILLATOR_DETECT_EN
  output logic             period2,
`endif
  output logic [1:0]       state_out
);

  state_t           st, st_d;
  cmd_t             cmd;
  logic             acc, tick;
  logic             pend, pend_d, rdy_d;
  logic [CELLS-1:0] board_d;
  logic [GEN_W-1:0] gen_d;
  logic             stable_d;
  logic             load;

  assign acc       = next_valid & next_ready;
  assign load      = (st == SETUP) & load_valid;
  assign state_out = st;

  gen_tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(st == RUN),
    .tick  (tick)
  );

  always_comb begin
    cmd = CMD_NONE;
    priority case (1'b1)
      cmd_edit:  cmd = CMD_EDIT;
      cmd_pause: cmd = CMD_PAUSE;
      cmd_step:  cmd = CMD_STEP;
      cmd_run:   cmd = CMD_RUN;
      default:   cmd = CMD_NONE;
    endcase
  end

  always_comb begin
    st_d = st;
    unique case (st)
      SETUP: begin
        if (cmd == CMD_RUN)       st_d = RUN;
        else if (cmd == CMD_STEP) st_d = STEP;
      end
      RUN: begin
        if (cmd == CMD_EDIT)       st_d = SETUP;
        else if (cmd == CMD_PAUSE) st_d = PAUSE;
      end
      PAUSE: begin
        if (cmd == CMD_EDIT)      st_d = SETUP;
        else if (cmd == CMD_RUN)  st_d = RUN;
        else if (cmd == CMD_STEP) st_d = STEP;
      end
      STEP: begin
        if (cmd == CMD_EDIT) st_d = SETUP;
        else if (acc)        st_d = PAUSE;
      end
      default: st_d = SETUP;
    endcase
  end

  always_comb begin
    board_d  = board_out;
    gen_d    = generation;
    stable_d = stable;
    if (acc) begin
      board_d  = next_board;
      gen_d    = generation + GEN_W'(1);
      stable_d = (next_board == board_out);
    end else if (load) begin
      board_d  = load_board;
      gen_d    = '0;
      stable_d = 1'b0;
    end
  end

  // A tick while already pending is simply absorbed.
  always_comb begin
    pend_d = pend;
    if (st_d != RUN) pend_d = 1'b0;
    else if (tick)   pend_d = 1'b1;
    else if (acc)    pend_d = 1'b0;
    rdy_d = ((st_d == RUN) & pend_d) | (st_d == STEP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= SETUP;
      pend       <= 1'b0;
      next_ready <= 1'b0;
      board_out  <= '0;
      generation <= '0;
      stable     <= 1'b0;
      extinct    <= 1'b1;
    end else begin
      st         <= st_d;
      pend       <= pend_d;
      next_ready <= rdy_d;
      board_out  <= board_d;
      generation <= gen_d;
      stable     <= stable_d;
      extinct    <= ~|board_d;
    end
  end

`ifdef OSCILLATOR_DETECT_EN
  logic [CELLS-1:0] prev_board;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_board <= '0;
      period2    <= 1'b0;
    end else if (acc) begin
      prev_board <= board_out;
      period2    <= (next_board == prev_board) &&
                    (next_board != board_out);
    end else if (load) begin
      period2    <= 1'b0;
    end
  end
`endif

endmodule
